// File: rtl/lifo_defs.sv
// Shared definitions for the LIFO stack: the {push,pop} request encoding
// and a clog2 helper for deriving pointer/count widths.
package lifo_defs;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// Stack storage: register array with one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module lifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with replace-top (push+pop), occupancy count,
// almost-full threshold and single-cycle overflow/underflow pulses.
module lifo_stack
    import lifo_defs::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    parameter  int AF_LEVEL   = DEPTH - 1,
    localparam int CW         = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  dout_valid,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [CW-1:0]         r_sp;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_af;
    logic                  r_ovf;
    logic                  r_unf;

    logic [1:0]            w_op;
    logic                  w_is_empty;
    logic                  w_is_full;
    logic [CW-1:0]         w_top;
    logic [CW-1:0]         w_sp_next;
    logic [CW-1:0]         w_waddr;
    logic                  w_we;
    logic                  w_pop_ok;
    logic                  w_ovf;
    logic                  w_unf;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_op       = {push, pop};
    assign w_is_empty = (r_sp == '0);
    assign w_is_full  = (r_sp == DEPTH_C);
    // Read index held at 0 when empty so the read never leaves the array.
    assign w_top      = w_is_empty ? '0 : r_sp - 1'b1;

    always_comb begin
        w_sp_next = r_sp;
        w_waddr   = r_sp;
        w_we      = 1'b0;
        w_pop_ok  = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        case (w_op)
            OP_IDLE: ;
            OP_PUSH: begin
                if (!w_is_full) begin
                    w_we      = 1'b1;
                    w_sp_next = r_sp + 1'b1;
                end else begin
                    w_ovf = 1'b1;
                end
            end
            OP_POP: begin
                if (!w_is_empty) begin
                    w_pop_ok  = 1'b1;
                    w_sp_next = r_sp - 1'b1;
                end else begin
                    w_unf = 1'b1;
                end
            end
            OP_SWAP: begin
                w_we = 1'b1;
                if (!w_is_empty) begin
                    // Replace-top: old top goes out, new word lands in its slot.
                    w_pop_ok = 1'b1;
                    w_waddr  = w_top;
                end else begin
                    w_unf     = 1'b1;
                    w_sp_next = r_sp + 1'b1;
                end
            end
            default: ;
        endcase
    end

    lifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (CW)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(data_in),
        .i_raddr(w_top),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_af         <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            r_sp         <= w_sp_next;
            r_dout_valid <= w_pop_ok;
            r_ovf        <= w_ovf;
            r_unf        <= w_unf;
            r_empty      <= (w_sp_next == '0);
            r_full       <= (w_sp_next == DEPTH_C);
            r_af         <= (w_sp_next >= AF_C);
            if (w_pop_ok) begin
                r_dout <= w_rdata;
            end
        end
    end

    assign data_out    = r_dout;
    assign dout_valid  = r_dout_valid;
    assign count       = r_sp;
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_af;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3):
// directed vector table, async-reset sequence, and random traffic vs a queue model.
module tb_lifo_stack;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          dout_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    lifo_stack #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_LEVEL  (AFL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .data_in    (data_in),
        .data_out   (data_out),
        .dout_valid (dout_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic [CW-1:0] cnt;
        logic [DW-1:0] dout;
        logic          v;
        logic          e;
        logic          f;
        logic          af;
        logic          o;
        logic          u;
    } vec_t;

    vec_t vq[$];

    // Behavioural model: a queue whose back is the top of stack.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [CW-1:0] cnt, input logic [DW-1:0] dout,
                           input logic v, input logic e, input logic f, input logic af,
                           input logic o, input logic u);
        chk({tag, ".count"},       32'(count),       32'(cnt));
        chk({tag, ".data_out"},    32'(data_out),    32'(dout));
        chk({tag, ".dout_valid"},  32'(dout_valid),  32'(v));
        chk({tag, ".empty"},       32'(empty),       32'(e));
        chk({tag, ".full"},        32'(full),        32'(f));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".overflow"},    32'(overflow),    32'(o));
        chk({tag, ".underflow"},   32'(underflow),   32'(u));
    endtask

    // Inputs are applied just after an edge and outputs sampled 1 ns after the next edge.
    task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    task automatic add(input logic p, input logic q, input logic [7:0] d, input int cnt,
                       input logic [7:0] dout, input logic v, input logic o, input logic u);
        vec_t r;
        r.push = p; r.pop = q; r.din = d; r.cnt = CW'(cnt); r.dout = dout; r.v = v;
        r.e  = (cnt == 0);
        r.f  = (cnt == DEPTH);
        r.af = (cnt >= AFL);
        r.o  = o; r.u = u;
        vq.push_back(r);
    endtask

    task automatic model_step(input logic p, input logic q, input logic [DW-1:0] d,
                              output logic v, output logic o, output logic u);
        int n;
        n = model_q.size();
        v = 1'b0; o = 1'b0; u = 1'b0;
        if (q && n == 0) u = 1'b1;
        if (p && !q && n == DEPTH) o = 1'b1;
        if (p && q && n > 0) begin
            model_dout = model_q[n-1];
            model_q[n-1] = d;
            v = 1'b1;
        end else if (p && (q || n < DEPTH)) begin
            model_q.push_back(d);
        end else if (q && n > 0) begin
            model_dout = model_q.pop_back();
            v = 1'b1;
        end
    endtask

    initial begin
        logic ev, eo, eu;
        int   n;
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 8'h00, 0, 1, 0, 0, 0, 0);
        reset = 1'b0;

        // push/pop/din, count, data_out, dout_valid, overflow, underflow
        add(1, 0, 8'h11, 1, 8'h00, 0, 0, 0);
        add(1, 0, 8'h22, 2, 8'h00, 0, 0, 0);
        add(1, 0, 8'h33, 3, 8'h00, 0, 0, 0);
        add(1, 0, 8'h44, 4, 8'h00, 0, 0, 0);
        add(1, 0, 8'h55, 4, 8'h00, 0, 1, 0);
        add(0, 0, 8'h00, 4, 8'h00, 0, 0, 0);
        add(0, 1, 8'h00, 3, 8'h44, 1, 0, 0);
        add(0, 1, 8'h00, 2, 8'h33, 1, 0, 0);
        add(0, 1, 8'h00, 1, 8'h22, 1, 0, 0);
        add(0, 1, 8'h00, 0, 8'h11, 1, 0, 0);
        add(0, 1, 8'h00, 0, 8'h11, 0, 0, 1);
        add(0, 0, 8'h00, 0, 8'h11, 0, 0, 0);
        add(1, 0, 8'hA0, 1, 8'h11, 0, 0, 0);
        add(1, 0, 8'hA1, 2, 8'h11, 0, 0, 0);
        add(1, 1, 8'hB0, 2, 8'hA1, 1, 0, 0);
        add(0, 1, 8'h00, 1, 8'hB0, 1, 0, 0);
        add(1, 0, 8'hC1, 2, 8'hB0, 0, 0, 0);
        add(1, 0, 8'hC2, 3, 8'hB0, 0, 0, 0);
        add(1, 0, 8'hC3, 4, 8'hB0, 0, 0, 0);
        add(1, 1, 8'hCC, 4, 8'hC3, 1, 0, 0);
        add(0, 1, 8'h00, 3, 8'hCC, 1, 0, 0);
        add(0, 1, 8'h00, 2, 8'hC2, 1, 0, 0);
        add(0, 1, 8'h00, 1, 8'hC1, 1, 0, 0);
        add(0, 1, 8'h00, 0, 8'hA0, 1, 0, 0);
        add(1, 1, 8'hD0, 1, 8'hA0, 0, 0, 1);
        add(0, 1, 8'h00, 0, 8'hD0, 1, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].push, vq[i].pop, vq[i].din);
            $display("vec %0d push=%0d pop=%0d din=%02h -> count=%0d dout=%02h v=%0d ovf=%0d unf=%0d",
                     i, vq[i].push, vq[i].pop, vq[i].din, count, data_out, dout_valid, overflow, underflow);
            chk_all($sformatf("vec%0d", i), vq[i].cnt, vq[i].dout, vq[i].v, vq[i].e,
                    vq[i].f, vq[i].af, vq[i].o, vq[i].u);
        end

        // Async reset mid-cycle with a dout_valid pulse live.
        step(1, 0, 8'h01);
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        step(1, 1, 8'h04);
        chk("pre_reset.dout_valid", 32'(dout_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        $display("async reset -> count=%0d empty=%0d dout=%02h v=%0d", count, empty, data_out, dout_valid);
        chk_all("async_reset", 0, 8'h00, 0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 1, 8'h00);
        $display("pop after reset -> count=%0d unf=%0d", count, underflow);
        chk_all("post_reset_pop", 0, 8'h00, 0, 1, 0, 0, 0, 1);

        // Random traffic against the queue model.
        model_q.delete();
        model_dout = 8'h00;
        for (int i = 0; i < 400; i++) begin
            logic p, q;
            logic [DW-1:0] d;
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            d = DW'($urandom);
            model_step(p, q, d, ev, eo, eu);
            step(p, q, d);
            n = model_q.size();
            $display("rnd %0d push=%0d pop=%0d din=%02h -> count=%0d dout=%02h v=%0d", i, p, q, d,
                     count, data_out, dout_valid);
            chk_all($sformatf("rnd%0d", i), CW'(n), model_dout, ev, (n == 0), (n == DEPTH),
                    (n >= AFL), eo, eu);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
Parametrised LIFO stack, the successor to the team's fixed two-entry LIFO. Supports arbitrary depth (not limited to powers of two) and simultaneous push+pop (replace-top). Outputs an occupancy count, an almost-full threshold flag, and single-cycle overflow/underflow error pulses. Used as a generic return-address / undo buffer between a producer and a consumer in one clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 4, number of entries; any integer >= 2
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
push  input  1  write data_in onto top of stack this cycle
pop  input  1  remove top of stack this cycle
data_in  input  DATA_WIDTH  push data
data_out  output  DATA_WIDTH  popped word, registered
dout_valid  output  1  one-cycle pulse: data_out updated by an accepted pop
count  output  CW  current number of stored entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LEVEL
overflow  output  1  one-cycle pulse: push rejected
underflow  output  1  one-cycle pulse: pop rejected

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values: count=0, empty=1, full=0, almost_full=0, data_out=0, dout_valid=0, overflow=0, underflow=0. Storage array is not reset.
- All outputs are registered. Flags and count reflect post-update state one cycle after the request edge.
- Internal state is a pointer `sp` = count. The top-of-stack entry is mem[sp-1]. No wrap-around: sp saturates within 0..DEPTH.
- Request decode each rising edge, evaluated on pre-edge state:
  - push only, not full: mem[sp] <= data_in; sp <= sp+1.
  - push only, full: word dropped; overflow=1 for one cycle; state unchanged.
  - pop only, not empty: data_out <= mem[sp-1]; dout_valid=1; sp <= sp-1.
  - pop only, empty: underflow=1 for one cycle; data_out holds its value; dout_valid=0.
  - push+pop, not empty (full included): data_out <= old mem[sp-1]; mem[sp-1] <= data_in; dout_valid=1; sp unchanged; no overflow.
  - push+pop, empty: underflow=1; the push is accepted as push-only (sp becomes 1); dout_valid=0.
  - neither: hold. dout_valid, overflow and underflow return to 0.
- data_out holds the last popped value until the next accepted pop.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). Requests in the cycle reset deasserts are ignored only if sampled while reset is still high.
- Width rules: sp and count are CW bits. Comparisons against DEPTH and AF_LEVEL are done at CW width. No arithmetic overflow is possible because sp is guarded by the full/empty checks.

Decomposition:
- Shared package/include lifo_defs: clog2 helper function, and request-decode localparams (OP_IDLE, OP_PUSH, OP_POP, OP_SWAP) forming a 2-bit {push,pop} op code.
- One sub-module, lifo_mem: DEPTH x DATA_WIDTH register array with one synchronous write port (addr, data, we) and one combinational read port. lifo_stack owns the pointer, flags and output registers.

Test Plan:
(All cases use DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3.)
1. Reset, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count 1,2,3,4; almost_full rises with count=3; full=1 after the 4th push; no overflow.
2. From full, push 0x55 -> overflow pulses for exactly 1 cycle; count stays 4. Then pop x4 -> data_out 0x44, 0x33, 0x22, 0x11, each with dout_valid=1; empty=1 at the end.
3. From empty, pop -> underflow pulses 1 cycle; data_out keeps 0x11; dout_valid=0; count=0.
4. Stack holds 0xA0, 0xA1; assert push+pop with data_in=0xB0 -> data_out=0xA1, dout_valid=1, count stays 2. Next pop -> data_out=0xB0.
5. From full, assert push+pop with 0xCC -> no overflow; count=4; data_out=old top. Also push+pop when empty -> underflow=1 and count=1.
6. Push 3 words, then assert reset asynchronously mid-cycle -> count=0, empty=1 and all pulses clear before the next clk edge. A subsequent pop gives underflow.
